// File: rtl/axis_packet_arbiter_pkg.sv
// rtl/axis_packet_arbiter_pkg.sv - shared types and constants for the packet arbiter
package processor_arbiter_config;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Source index width for the default four-source build
    localparam int SRC_W = 2;

    localparam int ABORT_BIT = 0;
    localparam int TRUNC_BIT = 1;

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// rtl/axis_packet_arbiter_if.sv - source-side and processor-side stream bundle
interface axis_packet_arbiter_if #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_W      = $clog2(NUM_SRC)
) ();
    logic [NUM_SRC-1:0]            s_tvalid;
    logic [NUM_SRC-1:0]            s_tready;
    logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
    logic [NUM_SRC-1:0]            s_tlast;
    logic                          m_tvalid;
    logic                          m_tready;
    logic [DATA_WIDTH-1:0]         m_tdata;
    logic                          m_tlast;
    logic [SRC_W-1:0]              m_tid;
    logic [1:0]                    m_tuser;

    modport master (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tuser
    );

    modport slave (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tid, m_tuser
    );
endinterface

// File: rtl/axis_packet_arbiter_rr_select.sv
// rtl/axis_packet_arbiter_rr_select.sv - first requester at or after ptr, modulo NUM_SRC
module axis_packet_arbiter_rr_select #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               any_req
);
    logic [NUM_SRC-1:0] rot;
    logic [SRC_W-1:0]   off;
    logic [SRC_W:0]     sum;

    always_comb begin
        rot = NUM_SRC'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) off = SRC_W'(i);
        end
        // Undo the rotation; one extra bit keeps ptr+off from wrapping early
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (SRC_W+1)'(NUM_SRC)) sum = sum - (SRC_W+1)'(NUM_SRC);
        gnt_idx = sum[SRC_W-1:0];
        any_req = |req;
    end
endmodule

// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - packet-granular round-robin stream arbiter
module axis_packet_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int STALL_TIMEOUT = 64,
    parameter int MAX_PKT_BEATS = 256,
    parameter int SRC_W         = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  arstn,
    axis_packet_arbiter_if.master bus,
    output logic                  busy,
    output logic [15:0]           stall_events
);
    import processor_arbiter_config::state_t;
    import processor_arbiter_config::IDLE;
    import processor_arbiter_config::GRANT;
    import processor_arbiter_config::FLUSH;
    import processor_arbiter_config::ABORT_BIT;
    import processor_arbiter_config::TRUNC_BIT;

    localparam int IDLE_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam int BEAT_W = (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]  grant_q, grant_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [15:0]       stall_q, stall_d;

    logic [SRC_W-1:0]  sel_idx;
    logic              sel_any;
    logic              src_valid;
    logic              src_last;
    logic              trunc_hit;
    logic              pkt_end;
    logic [SRC_W-1:0]  next_ptr;

    axis_packet_arbiter_rr_select #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_rr_select (
        .req     (bus.s_tvalid),
        .ptr     (rr_ptr_q),
        .gnt_idx (sel_idx),
        .any_req (sel_any)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        idle_cnt_d   = idle_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        stall_d      = stall_q;
        bus.s_tready = '0;
        bus.m_tvalid = 1'b0;
        bus.m_tdata  = '0;
        bus.m_tlast  = 1'b0;
        bus.m_tid    = '0;
        bus.m_tuser  = 2'b00;

        src_valid = bus.s_tvalid[grant_q];
        src_last  = bus.s_tlast[grant_q];
        trunc_hit = (MAX_PKT_BEATS != 0) && (int'(beat_cnt_q) == MAX_PKT_BEATS - 1);
        pkt_end   = src_last | trunc_hit;
        next_ptr  = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + SRC_W'(1);

        case (state_q)
            IDLE: begin
                idle_cnt_d = '0;
                beat_cnt_d = '0;
                if (sel_any) begin
                    grant_d = sel_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bus.m_tvalid           = src_valid;
                bus.m_tdata            = bus.s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                bus.m_tlast            = pkt_end;
                bus.m_tid              = grant_q;
                bus.m_tuser[TRUNC_BIT] = trunc_hit & ~src_last;
                bus.s_tready[grant_q]  = bus.m_tready;
                if (src_valid && bus.m_tready) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    idle_cnt_d = '0;
                    if (pkt_end) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr;
                        beat_cnt_d = '0;
                    end
                end else if (!src_valid) begin
                    // Backpressure with valid held high is not a stall
                    if (STALL_TIMEOUT != 0 && int'(idle_cnt_q) == STALL_TIMEOUT - 1) begin
                        state_d = FLUSH;
                    end else begin
                        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            FLUSH: begin
                bus.m_tvalid           = 1'b1;
                bus.m_tlast            = 1'b1;
                bus.m_tid              = grant_q;
                bus.m_tuser[ABORT_BIT] = 1'b1;
                if (bus.m_tready) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                    stall_d  = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            idle_cnt_q <= '0;
            beat_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            idle_cnt_q <= idle_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign stall_events = stall_q;
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - directed and random checks of the packet arbiter
module tb_axis_packet_arbiter;
    localparam int NS = 4;
    localparam int DW = 32;
    localparam int ST = 8;
    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        busy;
    logic [15:0] stall_events;

    always #5 clk = ~clk;

    axis_packet_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

    axis_packet_arbiter #(
        .NUM_SRC(NS), .DATA_WIDTH(DW), .STALL_TIMEOUT(ST), .MAX_PKT_BEATS(MB)
    ) dut (
        .clk(clk), .arstn(arstn), .bus(bus), .busy(busy), .stall_events(stall_events)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  tid;
        logic [1:0]  user;
        logic [31:0] cyc;
    } beat_t;

    logic [32:0] src_q [NS][$];
    logic [32:0] mdl_q [NS][$];
    beat_t       obs_q[$];
    beat_t       exp_q[$];
    logic        mvalid_log [int];
    logic        busy_log [int];
    logic        pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at negedge; outputs are sampled 1 ns later, well before the next posedge
    task automatic step(logic rdy);
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            if (src_q[i].size() > 0) begin
                bus.s_tvalid[i]          = 1'b1;
                bus.s_tlast[i]           = src_q[i][0][32];
                bus.s_tdata[i*DW +: DW]  = src_q[i][0][31:0];
            end else begin
                bus.s_tvalid[i]          = 1'b0;
                bus.s_tlast[i]           = 1'b0;
                bus.s_tdata[i*DW +: DW]  = '0;
            end
        end
        bus.m_tready = rdy;
        #1;
        mvalid_log[cyc] = bus.m_tvalid;
        busy_log[cyc]   = busy;
        check("ready_onehot", 64'($countones(bus.s_tready) <= 1), 64'd1);
        if (bus.m_tvalid && bus.m_tready)
            obs_q.push_back({bus.m_tdata, bus.m_tlast, bus.m_tid, bus.m_tuser, 32'(cyc)});
        for (int i = 0; i < NS; i++) begin
            if (bus.s_tvalid[i] && bus.s_tready[i]) void'(src_q[i].pop_front());
        end
        cyc++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        arstn = 1'b0;
        clear_all();
        step(1'b0);
        step(1'b0);
        arstn = 1'b1;
    endtask

    task automatic load_pkt(int s, int n, logic [31:0] base, logic with_last);
        logic [32:0] w;
        for (int b = 0; b < n; b++) begin
            w = {with_last && (b == n - 1), base + 32'(b)};
            src_q[s].push_back(w);
            mdl_q[s].push_back(w);
        end
    endtask

    // Packet-level reference: round-robin over preloaded packets, MB-beat chunks,
    // and a zero filler beat when a source runs dry before its tlast.
    task automatic run_model(int start_ptr);
        int ptr;
        int s;
        int n;
        logic done;
        logic [32:0] w;
        ptr = start_ptr;
        while (1) begin
            s = -1;
            for (int k = 0; k < NS; k++)
                if (s < 0 && mdl_q[(ptr + k) % NS].size() > 0) s = (ptr + k) % NS;
            if (s < 0) break;
            n = 0;
            done = 1'b0;
            while (!done) begin
                if (mdl_q[s].size() == 0) begin
                    exp_q.push_back({32'h0, 1'b1, 2'(s), 2'b01, 32'h0});
                    done = 1'b1;
                end else begin
                    w = mdl_q[s].pop_front();
                    n++;
                    exp_q.push_back({w[31:0], w[32] || n == MB, 2'(s),
                                     (n == MB) && !w[32], 1'b0, 32'h0});
                    done = w[32] || n == MB;
                end
            end
            ptr = (s + 1) % NS;
        end
    endtask

    task automatic run_until(int budget, logic rand_rdy);
        for (int i = 0; i < budget && obs_q.size() < exp_q.size(); i++)
            step(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1);
    endtask

    task automatic compare_all(string tag);
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
            check({tag, "_last"}, 64'(obs_q[i].last), 64'(exp_q[i].last));
            check({tag, "_tid"},  64'(obs_q[i].tid),  64'(exp_q[i].tid));
            check({tag, "_user"}, 64'(obs_q[i].user), 64'(exp_q[i].user));
        end
    endtask

    initial begin
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b0;

        step(1'b1);
        check("rst_mvalid", 64'(bus.m_tvalid), 64'd0);
        check("rst_sready", 64'(bus.s_tready), 64'd0);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_stall",  64'(stall_events), 64'd0);
        check("rst_tuser",  64'(bus.m_tuser), 64'd0);
        arstn = 1'b1;

        // Single packet from src2
        do_reset();
        load_pkt(2, 3, 32'hA0, 1'b1);
        start = cyc;
        for (int i = 0; i < 6; i++) step(1'b1);
        check("t1_bubble", 64'(mvalid_log[start]), 64'd0);
        check("t1_count", 64'(obs_q.size()), 64'd3);
        for (int i = 0; i < obs_q.size() && i < 3; i++) begin
            check("t1_data", 64'(obs_q[i].data), 64'(32'hA0 + 32'(i)));
            check("t1_tid",  64'(obs_q[i].tid), 64'd2);
            check("t1_last", 64'(obs_q[i].last), 64'(i == 2));
            check("t1_cyc",  64'(obs_q[i].cyc), 64'(start + 1 + i));
        end
        check("t1_busy_on",   64'(busy_log[start + 3]), 64'd1);
        check("t1_busy_drop", 64'(busy_log[start + 4]), 64'd0);

        // Fairness: every source holds two 2-beat packets
        do_reset();
        for (int s = 0; s < NS; s++)
            for (int p = 0; p < 2; p++) load_pkt(s, 2, 32'(s * 256 + p * 16), 1'b1);
        run_model(0);
        run_until(100, 1'b0);
        compare_all("t2");
        for (int k = 0; k < 5; k++)
            if (2 * k < obs_q.size()) check("t2_order", 64'(obs_q[2*k].tid), 64'(k % NS));

        // Backpressure on a src1 packet
        do_reset();
        load_pkt(1, 4, 32'hB0, 1'b1);
        run_model(0);
        for (int i = 0; i < 8; i++) begin
            step(pat[i]);
            if (i >= 1 && i <= 6) check("t3_sready", 64'(bus.s_tready[1]), 64'(pat[i]));
        end
        compare_all("t3");
        check("t3_no_stall", 64'(stall_events), 64'd0);

        // Truncation: 6 beats without tlast, limit 4
        do_reset();
        load_pkt(1, 6, 32'h10, 1'b0);
        load_pkt(2, 1, 32'h20, 1'b1);
        load_pkt(3, 1, 32'h30, 1'b1);
        run_model(0);
        run_until(60, 1'b0);
        compare_all("t5");
        if (obs_q.size() > 6) begin
            check("t5_trunc_user", 64'(obs_q[3].user), 64'd2);
            check("t5_trunc_last", 64'(obs_q[3].last), 64'd1);
            check("t5_after_tid",  64'(obs_q[4].tid), 64'd2);
            check("t5_rest_tid",   64'(obs_q[6].tid), 64'd1);
            check("t5_rest_data",  64'(obs_q[6].data), 64'h14);
        end

        // Stall watchdog
        do_reset();
        load_pkt(0, 1, 32'hC0, 1'b0);
        load_pkt(3, 2, 32'hD0, 1'b1);
        run_model(0);
        start = cyc;
        for (int i = 0; i < 20; i++) step(1'b1);
        compare_all("t4");
        check("t4_stall_events", 64'(stall_events), 64'd1);
        if (obs_q.size() > 2) begin
            check("t4_filler_cyc", 64'(obs_q[1].cyc), 64'(start + 10));
            check("t4_next_tid",   64'(obs_q[2].tid), 64'd3);
        end

        // Asynchronous reset mid-packet
        clear_all();
        load_pkt(2, 4, 32'hE0, 1'b1);
        step(1'b1);
        step(1'b1);
        @(negedge clk);
        #3;
        arstn = 1'b0;
        #1;
        check("t6_mvalid", 64'(bus.m_tvalid), 64'd0);
        check("t6_sready", 64'(bus.s_tready), 64'd0);
        check("t6_busy",   64'(busy), 64'd0);
        check("t6_stall",  64'(stall_events), 64'd0);
        clear_all();
        step(1'b1);
        step(1'b1);
        arstn = 1'b1;
        load_pkt(3, 1, 32'hF3, 1'b1);
        load_pkt(0, 1, 32'hF0, 1'b1);
        run_model(0);
        run_until(40, 1'b0);
        compare_all("t6");
        if (obs_q.size() > 0) check("t6_first_tid", 64'(obs_q[0].tid), 64'd0);

        // Random packets with random processor backpressure
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int s = 0; s < NS; s++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++)
                    load_pkt(s, $urandom_range(1, 6), $urandom, 1'b1);
            end
            run_model(0);
            run_until(600, 1'b1);
            compare_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule
